// File: rtl/arb_pkg.sv
// Shared types and constants for the IF/DM memory bus arbiter.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   localparam logic OWNER_IF = 1'b0;
   localparam logic OWNER_DM = 1'b1;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // Watchdog counter is never narrower than 8 bits.
   function automatic int wd_cnt_width(input int max_wait);
      int w;
      w = $clog2(max_wait + 1);
      return (w < 8) ? 8 : w;
   endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle watchdog: counts cycles since clr_i while en_i is high and flags
// the cycle in which the count reaches MAX_WAIT (MAX_WAIT = 0 disables it).
module arb_watchdog
   import arb_pkg::*;
#(
   parameter int MAX_WAIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic timeout_o
);

   localparam int CNT_W = wd_cnt_width(MAX_WAIT);

   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_inc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Fires during the MAX_WAIT-th busy cycle, so the abort lands after exactly MAX_WAIT cycles.
   generate
      if (MAX_WAIT == 0) begin : g_off
         assign timeout_o = 1'b0;
      end else begin : g_on
         assign timeout_o = en_i && (cnt_inc == CNT_W'(MAX_WAIT));
      end
   endgenerate

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Build option ARB_RR_EN: round-robin tie breaking instead of fixed DM priority.
module mem_bus_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              dm_read,
   input  logic [3:0]        dm_write,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ready,
   output logic              mem_req,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              waiting,
   output logic              bus_err,
   output arb_state_t        dbg_state
);

   // Handshake: a requester holds its request level until its one-cycle ready
   // pulse and drops or changes it at the end of that cycle; memory sees
   // mem_req high for the whole transaction and answers with a one-cycle mem_ack.

   arb_state_t        state_q, state_d;
   logic              owner_q, owner_d;
   logic              mem_req_q, mem_req_d;
   logic [3:0]        mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              bus_err_q, bus_err_d;

   logic dm_req, grant_dm, wd_clr, wd_busy, wd_timeout;

   assign dm_req = dm_read | (|dm_write);

`ifdef ARB_RR_EN
   // owner_q doubles as last_owner: on a tie, the side not served last wins.
   assign grant_dm = dm_req & (~if_req | (owner_q == OWNER_IF));
`else
   assign grant_dm = dm_req;
`endif

   assign wd_busy = (state_q == BUSY_I) || (state_q == BUSY_D);

   arb_watchdog #(.MAX_WAIT(MAX_WAIT)) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (wd_clr),
      .en_i     (wd_busy),
      .timeout_o(wd_timeout)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      bus_err_d   = bus_err_q;
      wd_clr      = 1'b0;
      case (state_q)
         IDLE: begin
            if (dm_req || if_req) begin
               wd_clr    = 1'b1;
               mem_req_d = 1'b1;
               if (grant_dm) begin
                  state_d     = BUSY_D;
                  owner_d     = OWNER_DM;
                  mem_we_d    = dm_write;
                  mem_addr_d  = dm_addr;
                  mem_wdata_d = dm_wdata;
               end else begin
                  state_d    = BUSY_I;
                  owner_d    = OWNER_IF;
                  mem_we_d   = 4'b0000;
                  mem_addr_d = if_addr;
               end
            end
         end
         BUSY_I, BUSY_D: begin
            // An ack in the timeout cycle takes precedence over the abort.
            if (mem_ack) begin
               state_d   = RESP;
               mem_req_d = 1'b0;
               if (state_q == BUSY_D) dm_rdata_d = mem_rdata;
               else                   if_rdata_d = mem_rdata;
            end else if (wd_timeout) begin
               state_d   = RESP;
               mem_req_d = 1'b0;
               bus_err_d = 1'b1;
               if (state_q == BUSY_D) dm_rdata_d = '0;
               else                   if_rdata_d = DATA_W'(NOP_INST);
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         owner_q     <= OWNER_IF;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 4'b0000;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign if_ready  = (state_q == RESP) && (owner_q == OWNER_IF);
   assign dm_ready  = (state_q == RESP) && (owner_q == OWNER_DM);
   assign waiting   = (if_req & ~if_ready) | (dm_req & ~dm_ready);
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign bus_err   = bus_err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = 4;

   logic          clk, rst;
   logic          if_req, if_ready, dm_read, dm_ready;
   logic [AW-1:0] if_addr, dm_addr, mem_addr;
   logic [DW-1:0] if_rdata, dm_rdata, dm_wdata, mem_wdata, mem_rdata;
   logic [3:0]    dm_write, mem_we;
   logic          mem_req, mem_ack, waiting, bus_err;
   logic [1:0]    dbg_state;

   int n_total = 0;
   int n_pass  = 0;

   mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .waiting(waiting), .bus_err(bus_err), .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic exp_wait(input logic ir, input logic dr);
      return (if_req & ~ir) | ((dm_read | (|dm_write)) & ~dr);
   endfunction

   // Transaction-level model: one outstanding transaction, a response cycle, then free.
   bit          m_busy, m_resp, m_dm, m_last_dm, m_err, m_dm_known;
   int          m_age;
   logic [31:0] m_addr, m_wdata, m_if_rd, m_dm_rd;
   logic [3:0]  m_we;

   initial begin
      logic e_ir, e_dr, d_req, pick_dm;
      m_busy = 0; m_resp = 0; m_dm = 0; m_last_dm = 0; m_err = 0; m_dm_known = 1;
      m_age = 0; m_addr = '0; m_wdata = '0; m_we = '0; m_if_rd = '0; m_dm_rd = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            m_busy = 0; m_resp = 0; m_dm = 0; m_last_dm = 0; m_err = 0; m_dm_known = 1;
            m_age = 0; m_if_rd = '0; m_dm_rd = '0;
            chk("rst mem_req", mem_req, 0);
            chk("rst if_ready", if_ready, 0);
            chk("rst dm_ready", dm_ready, 0);
            chk("rst bus_err", bus_err, 0);
            chk("rst mem_we", mem_we, 0);
            chk("rst mem_addr", mem_addr, 0);
            chk("rst mem_wdata", mem_wdata, 0);
            chk("rst if_rdata", if_rdata, 0);
            chk("rst dm_rdata", dm_rdata, 0);
            chk("rst state", dbg_state, 0);
            chk("rst waiting", waiting, exp_wait(1'b0, 1'b0));
         end else begin
            e_ir = m_resp && !m_dm;
            e_dr = m_resp && m_dm;
            chk("mem_req", mem_req, m_busy);
            if (m_busy) begin
               chk("mem_addr", mem_addr, m_addr);
               chk("mem_we", mem_we, m_we);
               if (m_we != 0) chk("mem_wdata", mem_wdata, m_wdata);
            end
            chk("if_ready", if_ready, e_ir);
            chk("dm_ready", dm_ready, e_dr);
            if (e_ir) chk("if_rdata", if_rdata, m_if_rd);
            if (e_dr && m_dm_known) chk("dm_rdata", dm_rdata, m_dm_rd);
            chk("bus_err", bus_err, m_err);
            chk("waiting", waiting, exp_wait(e_ir, e_dr));
            // advance to what the next clock edge must produce
            if (m_resp) begin
               m_resp = 0;
            end else if (m_busy) begin
               m_age++;
               if (mem_ack) begin
                  m_busy = 0; m_resp = 1;
                  if (m_dm) begin m_dm_rd = mem_rdata; m_dm_known = (m_we == 0); end
                  else m_if_rd = mem_rdata;
               end else if (MW != 0 && m_age == MW) begin
                  m_busy = 0; m_resp = 1; m_err = 1;
                  if (m_dm) begin m_dm_rd = '0; m_dm_known = 1; end
                  else m_if_rd = 32'h0000_0013;
               end
            end else begin
               d_req = dm_read | (|dm_write);
               if (d_req || if_req) begin
`ifdef ARB_RR_EN
                  pick_dm = d_req && (!if_req || !m_last_dm);
`else
                  pick_dm = d_req;
`endif
                  m_busy = 1; m_age = 0; m_dm = pick_dm; m_last_dm = pick_dm;
                  if (pick_dm) begin m_addr = dm_addr; m_we = dm_write; m_wdata = dm_wdata; end
                  else begin m_addr = if_addr; m_we = 4'b0000; end
               end
            end
         end
      end
   end

   // Acks every transaction immediately and drops requests on ready.
   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         mem_ack = mem_req;
         if (if_ready) if_req = 0;
         if (dm_ready) begin dm_read = 0; dm_write = 0; end
         tick();
      end
      mem_ack = 0;
   endtask

   initial begin
      int   r_cnt, r_dly;
      logic dq, d_start, i_start;
      rst = 0; if_req = 0; if_addr = '0; dm_read = 0; dm_write = '0; dm_addr = '0;
      dm_wdata = '0; mem_rdata = '0; mem_ack = 0;
      repeat (3) tick();
      rst = 1;
      tick();

      // 1: lone fetch, ack in the third busy cycle
      if_req = 1; if_addr = 32'h40;
      tick();
      chk("t1 mem_req", mem_req, 1);
      chk("t1 mem_we", mem_we, 0);
      chk("t1 mem_addr", mem_addr, 32'h40);
      chk("t1 waiting busy", waiting, 1);
      tick(); tick();
      mem_ack = 1; mem_rdata = 32'h00A0_0093;
      tick();
      mem_ack = 0; mem_rdata = $urandom;
      chk("t1 if_ready", if_ready, 1);
      chk("t1 if_rdata", if_rdata, 32'h00A0_0093);
      chk("t1 mem_req resp", mem_req, 0);
      if_req = 0;
      tick();
      chk("t1 if_ready after", if_ready, 0);
      chk("t1 waiting after", waiting, 0);

      // 2: tie, DM served first, IF after a two-cycle gap
      if_req = 1; if_addr = 32'h80; dm_read = 1; dm_addr = 32'h100;
      tick();
      chk("t2 first addr", mem_addr, 32'h100);
      chk("t2 first we", mem_we, 0);
      mem_ack = 1; mem_rdata = 32'h1111_1111;
      tick();
      mem_ack = 0;
      chk("t2 dm_ready", dm_ready, 1);
      chk("t2 dm_rdata", dm_rdata, 32'h1111_1111);
      chk("t2 if_ready early", if_ready, 0);
      dm_read = 0;
      tick();
      chk("t2 gap mem_req", mem_req, 0);
      tick();
      chk("t2 second mem_req", mem_req, 1);
      chk("t2 second addr", mem_addr, 32'h80);
      mem_ack = 1; mem_rdata = 32'h2222_2222;
      tick();
      mem_ack = 0;
      chk("t2 if_ready", if_ready, 1);
      chk("t2 if_rdata", if_rdata, 32'h2222_2222);
      if_req = 0;
      tick();

      // 3: partial write held stable through BUSY while dm_wdata wanders
      dm_write = 4'b0011; dm_wdata = 32'hDEAD_BEEF; dm_addr = 32'h200;
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("t3 mem_req", mem_req, 1);
         chk("t3 mem_we", mem_we, 4'b0011);
         chk("t3 mem_wdata", mem_wdata, 32'hDEAD_BEEF);
         chk("t3 mem_addr", mem_addr, 32'h200);
         dm_wdata = $urandom;
         if (i == 2) mem_ack = 1;
         tick();
      end
      mem_ack = 0;
      chk("t3 dm_ready", dm_ready, 1);
      dm_write = 0;
      tick();
      chk("t3 dm_ready once", dm_ready, 0);

      // 2b: tie right after a DM grant
      if_req = 1; if_addr = 32'h700; dm_read = 1; dm_addr = 32'h704;
      tick();
`ifdef ARB_RR_EN
      chk("t2b tie winner", mem_addr, 32'h700);
`else
      chk("t2b tie winner", mem_addr, 32'h704);
`endif
      drain();

      // 4: no ack, watchdog abort after MW busy cycles
      if_req = 1; if_addr = 32'h300;
      tick();
      for (int i = 0; i < MW; i++) begin
         chk("t4 mem_req held", mem_req, 1);
         chk("t4 bus_err pre", bus_err, 0);
         tick();
      end
      chk("t4 if_ready", if_ready, 1);
      chk("t4 if_rdata nop", if_rdata, 32'h0000_0013);
      chk("t4 bus_err", bus_err, 1);
      chk("t4 mem_req dropped", mem_req, 0);
      if_req = 0;
      tick(); tick();
      chk("t4 bus_err sticky", bus_err, 1);

      // 5: reset during a DM transaction
      dm_read = 1; dm_addr = 32'h500;
      tick();
      chk("t5 mem_req busy", mem_req, 1);
      #1 rst = 0;
      #1 chk("t5 async mem_req", mem_req, 0);
      chk("t5 bus_err cleared", bus_err, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5 no dm_ready", dm_ready, 0);
      end
      rst = 1;
      tick();
      chk("t5 regrant", mem_req, 1);
      chk("t5 regrant addr", mem_addr, 32'h500);
      mem_ack = 1; mem_rdata = 32'h5555_AAAA;
      tick();
      mem_ack = 0;
      chk("t5 dm_ready", dm_ready, 1);
      chk("t5 dm_rdata", dm_rdata, 32'h5555_AAAA);
      dm_read = 0;
      tick();

      // 6: ack in the timeout cycle wins
      if_req = 1; if_addr = 32'h600;
      tick(); tick(); tick(); tick();
      mem_ack = 1; mem_rdata = 32'h00B0_0113;
      tick();
      mem_ack = 0;
      chk("t6 if_ready", if_ready, 1);
      chk("t6 if_rdata", if_rdata, 32'h00B0_0113);
      chk("t6 bus_err", bus_err, 0);
      if_req = 0;
      tick();
      chk("t6 bus_err after", bus_err, 0);

      // random traffic with random memory latency, stray acks and reset pulses
      r_cnt = 0; r_dly = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (if_req && if_ready) begin
            if_req = 0;
            i_start = ($urandom_range(0, 1) == 1);
         end else begin
            i_start = !if_req && ($urandom_range(0, 3) == 0);
         end
         if (i_start) begin if_req = 1; if_addr = $urandom; end

         dq = dm_read | (|dm_write);
         if (dq && dm_ready) begin
            dm_read = 0; dm_write = 0;
            d_start = ($urandom_range(0, 1) == 1);
         end else begin
            d_start = !dq && ($urandom_range(0, 3) == 0);
         end
         if (d_start) begin
            dm_addr = $urandom; dm_wdata = $urandom;
            if ($urandom_range(0, 1) == 1) begin
               dm_write = 4'($urandom_range(1, 15));
               dm_read  = 1'($urandom_range(0, 1));
            end else begin
               dm_write = 4'b0000;
               dm_read  = 1;
            end
         end

         mem_rdata = $urandom;
         if (mem_req) begin
            if (r_cnt == 0) r_dly = $urandom_range(0, MW + 1);
            mem_ack = (r_cnt == r_dly);
            r_cnt++;
         end else begin
            r_cnt = 0;
            mem_ack = ($urandom_range(0, 7) == 0);
         end

         if (cyc % 700 == 350) rst = 0;
         if (cyc % 700 == 353) rst = 1;
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
